// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Address gating keeps the zero register and out-of-range indices out of all state.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // True when an address maps to a real, writable register.
  function automatic logic addr_live(input logic [31:0] addr, input int num_regs,
                                     input bit zero_reg);
    return (addr < $unsigned(num_regs)) && !(zero_reg && (addr == 32'd0));
  endfunction

  function automatic logic wr_gate(input logic en, input logic [31:0] addr,
                                   input int num_regs, input bit zero_reg);
    return en && addr_live(addr, num_regs, zero_reg);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: reservation acceptance, pending population count, sticky error.
// rsv_ok is combinational; state updates on the rising edge, no back-pressure beyond rsv_ok.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0,
  parameter int CW       = cnt_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ok,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic [CW-1:0]       pending_cnt,
  output logic                err_wb_unrsv
);

  logic                rsv_live;
  logic                wb_live;
  logic                rsv_set;
  logic                wb_clr;
  logic                wb_orphan;
  logic [NUM_REGS-1:0] pending_nxt;

  always_comb begin
    rsv_live  = addr_live(32'(rsv_addr), NUM_REGS, ZERO_REG != 0);
    wb_live   = wr_gate(wb_en, 32'(wb_addr), NUM_REGS, ZERO_REG != 0);
    wb_clr    = wb_live && pending[wb_addr];
    wb_orphan = wb_live && !pending[wb_addr];
    // Zero/out-of-range destinations are always accepted but never tracked.
    rsv_ok    = rsv_en && (!rsv_live || !pending[rsv_addr] ||
                           (wb_en && (wb_addr == rsv_addr)));
    rsv_set   = rsv_ok && rsv_live;
    pending_nxt = pending;
    if (wb_clr)  pending_nxt[wb_addr]  = 1'b0;
    if (rsv_set) pending_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      pending_cnt  <= '0;
      err_wb_unrsv <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (rsv_set && !wb_clr)
        pending_cnt <= pending_cnt + CW'(1);
      else if (wb_clr && !rsv_set)
        pending_cnt <= pending_cnt - CW'(1);
      if (wb_orphan)
        err_wb_unrsv <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one writeback port and per-register scoreboard.
// Read latency 0 (optional writeback bypass); no back-pressure, decode stalls on busy or !rsv_ok.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           rd_addr1,
  input  logic [ADDR_W-1:0]           rd_addr2,
  output logic [DATA_W-1:0]           rd_data1,
  output logic [DATA_W-1:0]           rd_data2,
  output logic                        rd_busy1,
  output logic                        rd_busy2,
  input  logic                        rsv_en,
  input  logic [ADDR_W-1:0]           rsv_addr,
  output logic                        rsv_ok,
  input  logic                        wb_en,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic [cnt_w(NUM_REGS)-1:0]  pending_cnt,
  output logic                        err_wb_unrsv
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wb_live;
  logic                fwd_ok;

  assign wb_live = wr_gate(wb_en, 32'(wb_addr), NUM_REGS, ZERO_REG != 0);
  // Forwarding is suppressed during reset so reads track the cleared array at once.
  assign fwd_ok  = (BYPASS != 0) && wb_live && !reset;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CW       (cnt_w(NUM_REGS))
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .rsv_ok       (rsv_ok),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .pending      (pending),
    .pending_cnt  (pending_cnt),
    .err_wb_unrsv (err_wb_unrsv)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_busy1 = 1'b0;
    if (addr_live(32'(rd_addr1), NUM_REGS, ZERO_REG != 0)) begin
      rd_data1 = regs[rd_addr1];
      rd_busy1 = pending[rd_addr1];
    end
    if (fwd_ok && (wb_addr == rd_addr1)) begin
      rd_data1 = wb_data;
      rd_busy1 = 1'b0;
    end
  end

  always_comb begin
    rd_data2 = '0;
    rd_busy2 = 1'b0;
    if (addr_live(32'(rd_addr2), NUM_REGS, ZERO_REG != 0)) begin
      rd_data2 = regs[rd_addr2];
      rd_busy2 = pending[rd_addr2];
    end
    if (fwd_ok && (wb_addr == rd_addr2)) begin
      rd_data2 = wb_data;
      rd_busy2 = 1'b0;
    end
  end

endmodule
